// File: rtl/mem_responder_multi.sv
// Memory-side responder for the multicycle RISC-V datapath: word RAM with byte-lane
// stores, a pipelined load path with sign/zero extension, and a two-state store FSM.
module mem_responder_multi #(
    parameter int          ADDR_WIDTH   = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    input  logic [2:0]  iFunct3,
    input  logic        iIsFetch,
    output logic [31:0] oReadData,
    output logic        oReadValid,
    output logic        oWriteAck,
    output logic        oFault
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        W_IDLE,
        W_HELD
    } wstate_e;

    logic [31:0] mem [DEPTH];

    logic [2:0]            funct3_eff;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  misaligned;
    logic                  rd_fault;
    logic                  wr_fault;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shifted;
    logic [31:0]           rd_ext;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;

    always_comb begin
        funct3_eff = iIsFetch ? 3'b010 : iFunct3;
        word_idx   = iAddress[ADDR_WIDTH+1:2];
        lane       = iAddress[1:0];
        in_range   = (iAddress[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
        misaligned = ((funct3_eff[1:0] == 2'b01) && lane[0])
                  || ((funct3_eff[1:0] == 2'b10) && (lane != 2'b00));
        rd_fault   = !in_range || misaligned
                  || !(funct3_eff inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        wr_fault   = !in_range || misaligned
                  || !(funct3_eff inside {3'b000, 3'b001, 3'b010});
    end

    // Load extraction: move the addressed byte/half to bit 0, then extend.
    always_comb begin
        rd_word    = mem[word_idx];
        rd_shifted = rd_word >> {lane, 3'b000};
        case (funct3_eff)
            3'b000:  rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  rd_ext = rd_word;
            3'b100:  rd_ext = {24'h0, rd_shifted[7:0]};
            3'b101:  rd_ext = {16'h0, rd_shifted[15:0]};
            default: rd_ext = 32'h0;
        endcase
    end

    always_comb begin
        case (funct3_eff[1:0])
            2'b00: begin
                wr_data = {4{iWriteData[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            2'b01: begin
                wr_data = {2{iWriteData[15:0]}};
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = iWriteData;
                wr_be   = 4'b1111;
            end
        endcase
    end

    wstate_e state_q, state_d;
    logic    ack_q, ack_d;
    logic    wfault_q, wfault_d;
    logic    do_write;

    // Read+write together is a conflict every cycle it is held, regardless of state.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        wfault_d = iMemRead && iMemWrite;
        do_write = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (iMemWrite) begin
                    state_d = W_HELD;
                    if (!iMemRead && !wr_fault) begin
                        do_write = 1'b1;
                        ack_d    = 1'b1;
                    end else begin
                        wfault_d = 1'b1;
                    end
                end
            end
            W_HELD: begin
                if (!iMemWrite) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= W_IDLE;
            ack_q    <= 1'b0;
            wfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wfault_q <= wfault_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (do_write && !iRST) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    logic        rd_sample;
    logic [31:0] s1_data_q, s1_data_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s1_fault_q, s1_fault_d;

    always_comb begin
        rd_sample  = iMemRead && !iMemWrite;
        s1_valid_d = rd_sample;
        s1_fault_d = rd_sample && rd_fault;
        s1_data_d  = s1_data_q;
        if (rd_sample) begin
            s1_data_d = rd_fault ? 32'h0 : rd_ext;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_data_q  <= 32'h0;
            s1_valid_q <= 1'b0;
            s1_fault_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s1_fault_q <= s1_fault_d;
        end
    end

    logic rd_fault_out;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [31:0] s2_data_q, s2_data_d;
            logic        s2_valid_q, s2_valid_d;
            logic        s2_fault_q, s2_fault_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_fault_d = s1_fault_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
            end

            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    s2_data_q  <= 32'h0;
                    s2_valid_q <= 1'b0;
                    s2_fault_q <= 1'b0;
                end else begin
                    s2_data_q  <= s2_data_d;
                    s2_valid_q <= s2_valid_d;
                    s2_fault_q <= s2_fault_d;
                end
            end

            assign oReadData    = s2_data_q;
            assign oReadValid   = s2_valid_q;
            assign rd_fault_out = s2_fault_q;
        end else begin : g_lat1
            assign oReadData    = s1_data_q;
            assign oReadValid   = s1_valid_q;
            assign rd_fault_out = s1_fault_q;
        end
    endgenerate

    assign oWriteAck = ack_q;
    assign oFault    = rd_fault_out || wfault_q;

endmodule

// File: tb/tb_mem_responder_multi.sv
// Scoreboard bench for mem_responder_multi: stimulus pushes expected responses,
// a negedge monitor pops one entry for every cycle the DUT shows any output.
module tb_mem_responder_multi;

    logic        clk = 1'b0;
    logic        iRST;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iAddress;
    logic [31:0] iWriteData;
    logic [2:0]  iFunct3;
    logic        iIsFetch;
    logic [31:0] oReadData;
    logic        oReadValid;
    logic        oWriteAck;
    logic        oFault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] data;
        logic        ack;
        logic        fault;
    } exp_t;

    exp_t expQ[$];
    exp_t got;

    always #5 clk = ~clk;

    mem_responder_multi #(
        .ADDR_WIDTH  (12),
        .BASE_ADDR   (32'h0000_0000),
        .READ_LATENCY(1)
    ) dut (
        .iCLK      (clk),
        .iRST      (iRST),
        .iMemRead  (iMemRead),
        .iMemWrite (iMemWrite),
        .iAddress  (iAddress),
        .iWriteData(iWriteData),
        .iFunct3   (iFunct3),
        .iIsFetch  (iIsFetch),
        .oReadData (oReadData),
        .oReadValid(oReadValid),
        .oWriteAck (oWriteAck),
        .oFault    (oFault)
    );

    // Every active output cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (oReadValid || oWriteAck || oFault) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output got valid=%0b data=%h ack=%0b fault=%0b, required no output",
                         oReadValid, oReadData, oWriteAck, oFault);
            end else begin
                got = expQ.pop_front();
                if (oReadValid !== got.valid || oWriteAck !== got.ack || oFault !== got.fault
                    || (got.valid && oReadData !== got.data)) begin
                    errors++;
                    $display("[TB] FAIL %s got valid=%0b data=%h ack=%0b fault=%0b, required valid=%0b data=%h ack=%0b fault=%0b",
                             got.name, oReadValid, oReadData, oWriteAck, oFault,
                             got.valid, got.data, got.ack, got.fault);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input string name, input logic v, input logic [31:0] d,
                                input logic a, input logic f);
        exp_t e;
        e.name  = name;
        e.valid = v;
        e.data  = d;
        e.ack   = a;
        e.fault = f;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3, input logic fetch);
        iMemRead   = rd;
        iMemWrite  = wr;
        iAddress   = addr;
        iWriteData = wdata;
        iFunct3    = f3;
        iIsFetch   = fetch;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        step();
    endtask

    task automatic doStore(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] f3, input int cycles, input logic legal);
        applyStimulus(1'b0, 1'b1, addr, data, f3, 1'b0);
        if (legal) pushExpected(name, 1'b0, 32'h0, 1'b1, 1'b0);
        else       pushExpected(name, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (cycles) step();
    endtask

    task automatic doLoad(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          input logic fetch, input int cycles, input logic [31:0] expData,
                          input logic expFault);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, f3, fetch);
        for (int i = 0; i < cycles; i++) begin
            pushExpected(name, 1'b1, expData, 1'b0, expFault);
            step();
        end
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expData,
                               input logic expAck, input logic expFault);
        checks++;
        if (oReadValid !== expValid || oReadData !== expData || oWriteAck !== expAck
            || oFault !== expFault) begin
            errors++;
            $display("[TB] FAIL %s got valid=%0b data=%h ack=%0b fault=%0b, required valid=%0b data=%h ack=%0b fault=%0b",
                     name, oReadValid, oReadData, oWriteAck, oFault,
                     expValid, expData, expAck, expFault);
        end
    endtask

    initial begin
        iRST = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        step();
        step();
        checkOutput("reset_state", 1'b0, 32'h0, 1'b0, 1'b0);
        iRST = 1'b0;
        idle();

        // Preload and fetch; fetch ignores the (illegal) funct3 on the bus.
        doStore("preload_sw_10", 32'h10, 32'h8899AABB, 3'b010, 1, 1'b1);
        idle();
        doLoad("fetch_10", 32'h10, 3'b111, 1'b1, 2, 32'h8899AABB, 1'b0);
        doLoad("lb_12",  32'h12, 3'b000, 1'b0, 1, 32'hFFFFFF99, 1'b0);
        doLoad("lbu_12", 32'h12, 3'b100, 1'b0, 1, 32'h00000099, 1'b0);
        doLoad("lh_12",  32'h12, 3'b001, 1'b0, 1, 32'hFFFF8899, 1'b0);
        doLoad("lhu_10", 32'h10, 3'b101, 1'b0, 1, 32'h0000AABB, 1'b0);
        doLoad("lb_11",  32'h11, 3'b000, 1'b0, 1, 32'hFFFFFFAA, 1'b0);
        doLoad("lbu_13", 32'h13, 3'b100, 1'b0, 1, 32'h00000088, 1'b0);
        idle();

        // Two-cycle SB window commits once; the load right after sees it.
        doStore("clear_sw_20", 32'h20, 32'h00000000, 3'b010, 1, 1'b1);
        idle();
        doStore("sb_21_held", 32'h21, 32'hFFFFFF5A, 3'b000, 2, 1'b1);
        doLoad("lw_20_after_sb", 32'h20, 3'b010, 1'b0, 1, 32'h00005A00, 1'b0);
        idle();
        doStore("sh_22", 32'h22, 32'h1234BEEF, 3'b001, 1, 1'b1);
        idle();
        doLoad("lw_20_after_sh", 32'h20, 3'b010, 1'b0, 1, 32'hBEEF5A00, 1'b0);
        idle();

        // Faulting stores and loads.
        doStore("sw_22_misaligned", 32'h22, 32'h11111111, 3'b010, 1, 1'b0);
        idle();
        doStore("store_illegal_f3", 32'h20, 32'h22222222, 3'b100, 1, 1'b0);
        idle();
        doLoad("lw_20_unchanged", 32'h20, 3'b010, 1'b0, 1, 32'hBEEF5A00, 1'b0);
        doLoad("lh_23_misaligned", 32'h23, 3'b001, 1'b0, 1, 32'h0, 1'b1);
        doLoad("load_illegal_f3", 32'h20, 3'b011, 1'b0, 1, 32'h0, 1'b1);
        idle();

        // Read and write together: fault only, RAM untouched, no read data.
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        pushExpected("rd_wr_conflict", 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        idle();
        doLoad("lw_10_after_conflict", 32'h10, 3'b010, 1'b0, 1, 32'h8899AABB, 1'b0);
        idle();

        // Outside the RAM region; the store must not alias onto word 0x10.
        doLoad("lw_out_of_range", 32'h4010, 3'b010, 1'b0, 1, 32'h0, 1'b1);
        idle();
        doStore("sw_out_of_range", 32'h4010, 32'h55555555, 3'b010, 1, 1'b0);
        idle();
        doLoad("lw_10_no_alias", 32'h10, 3'b010, 1'b0, 1, 32'h8899AABB, 1'b0);
        idle();

        // Reset on the commit edge of a store.
        doStore("preload_sw_30", 32'h30, 32'hCAFEF00D, 3'b010, 1, 1'b1);
        idle();
        applyStimulus(1'b0, 1'b1, 32'h30, 32'h12345678, 3'b010, 1'b0);
        iRST = 1'b1;
        step();
        checkOutput("reset_on_commit", 1'b0, 32'h0, 1'b0, 1'b0);
        iRST = 1'b0;
        idle();
        checkOutput("after_reset", 1'b0, 32'h0, 1'b0, 1'b0);
        doLoad("lw_30_after_reset", 32'h30, 3'b010, 1'b0, 1, 32'hCAFEF00D, 1'b0);
        idle();
        doStore("sw_30_post_reset", 32'h30, 32'h0F0F0F0F, 3'b010, 1, 1'b1);
        idle();
        doLoad("lw_30_final", 32'h30, 3'b010, 1'b0, 1, 32'h0F0F0F0F, 1'b0);
        idle();

        repeat (3) step();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_outputs got %0d pending, required 0 (first pending %s)",
                     expQ.size(), expQ[0].name);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
